// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   state_t      : loader FSM states
//   WORD_BYTES   : bytes per instruction word
//   HDR_BYTES    : bytes in the word-count header
//   ADDR_STRIDE  : byte-address step between consecutive words
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      LOAD  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   localparam int          WORD_BYTES  = 4;
   localparam int          HDR_BYTES   = 2;
   localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage

// File: rtl/byte_assembler.sv
// Packs a big-endian byte stream into instruction words.
//   clk, rst       : clock, asynchronous active-low reset
//   clear          : synchronous clear of the partial word and byte index
//   accept         : a byte is transferred this cycle
//   byte_in        : the transferred byte
//   word           : current partial word with byte_in as the last byte
//   word_complete  : accept of the final byte of a word; word is valid now
module byte_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_complete
);

   localparam int IDX_W = $clog2(WORD_BYTES);
   localparam int SH_W  = (WORD_BYTES - 1) * 8;

   // Only the leading bytes need storage; the last byte is taken straight
   // from the input so the word is available on the edge that accepts it.
   logic [SH_W-1:0]  shreg;
   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
         idx   <= '0;
      end else if (clear) begin
         shreg <= '0;
         idx   <= '0;
      end else if (accept) begin
         shreg <= {shreg[SH_W-9:0], byte_in};
         idx   <= idx + IDX_W'(1);   // wraps 3 -> 0
      end
   end

   assign word          = {shreg, byte_in};
   assign word_complete = accept && (idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction loader. Takes a byte stream (2-byte big-endian word
// count, then big-endian 32-bit words) and writes each word into the core's
// instruction memory, holding the core in reset until the load completes.
//   clk, rst                        : clock, asynchronous active-low reset
//   start                           : pulse; begins a load from IDLE/DONE/ERR
//   byte_data/byte_valid/byte_ready : input byte stream handshake
//   initialize                      : one-cycle memory write strobe per word
//   instruction_initialize_data     : word being written
//   instruction_initialize_address  : byte address of that word
//   cpu_rst                         : core reset, released only in DONE
//   busy / done / error             : load status
//   words_loaded                    : words written in the current load
module program_loader
   import loader_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             initialize,
   output logic [31:0]      instruction_initialize_data,
   output logic [31:0]      instruction_initialize_address,
   output logic             cpu_rst,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_loaded
);

   state_t           state, next_state;
   logic             hdr_idx;
   logic [7:0]       hdr_hi;
   logic [CNT_W-1:0] count;
   logic [15:0]      hdr_word;
   logic             hdr_take, hdr_last, start_ok;
   logic             asm_accept, word_complete;
   logic [31:0]      asm_word;
   logic [CNT_W-1:0] wl_next;

   // Ready depends on state only, so the upstream can never form a loop
   // through byte_valid.
   assign byte_ready = (state == HDR) || (state == LOAD);
   assign initialize = (state == WRITE);
   assign busy       = (state == HDR) || (state == LOAD) || (state == WRITE);

   assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign hdr_take   = (state == HDR) && byte_valid;
   assign hdr_last   = hdr_take && (hdr_idx == 1'(HDR_BYTES - 1));
   assign hdr_word   = {hdr_hi, byte_data};
   assign asm_accept = (state == LOAD) && byte_valid;
   assign wl_next    = words_loaded + CNT_W'(1);

   byte_assembler u_asm (
      .clk           (clk),
      .rst           (rst),
      .clear         (start_ok),
      .accept        (asm_accept),
      .byte_in       (byte_data),
      .word          (asm_word),
      .word_complete (word_complete)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE, ERR: if (start) next_state = HDR;
         HDR: begin
            if (hdr_last) begin
               if (hdr_word == 16'd0)                  next_state = DONE;
               else if (32'(hdr_word) > 32'(DEPTH))    next_state = ERR;
               else                                    next_state = LOAD;
            end
         end
         LOAD:    if (word_complete) next_state = WRITE;
         WRITE:   next_state = (wl_next == count) ? DONE : LOAD;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_idx                        <= 1'b0;
         hdr_hi                         <= '0;
         count                          <= '0;
         instruction_initialize_data    <= '0;
         instruction_initialize_address <= BASE_ADDR;
         words_loaded                   <= '0;
         cpu_rst                        <= 1'b1;
         done                           <= 1'b0;
         error                          <= 1'b0;
      end else begin
         // Status flags are registered from next_state so they line up with
         // the state they describe and cannot glitch. done/error hold for as
         // long as DONE/ERR is held and clear on the restarting start.
         cpu_rst <= (next_state != DONE);
         done    <= (next_state == DONE);
         error   <= (next_state == ERR);

         if (start_ok) begin
            hdr_idx                        <= 1'b0;
            words_loaded                   <= '0;
            instruction_initialize_address <= BASE_ADDR;
         end

         if (hdr_take) begin
            hdr_hi  <= byte_data;
            hdr_idx <= hdr_last ? 1'b0 : hdr_idx + 1'b1;
            if (hdr_last) count <= CNT_W'(hdr_word);
         end

         if (word_complete) instruction_initialize_data <= asm_word;

         if (state == WRITE) begin
            words_loaded                   <= wl_next;
            instruction_initialize_address <= instruction_initialize_address + ADDR_STRIDE;
         end
      end
   end

endmodule
